// File: rtl/experiment_sequencer.sv
// Multi-shot sequencer: drives exp_start through N shots with inter-shot gap,
// per-shot watchdog, FSM reset recovery and abort handling.
//
// Ports:
//   clock, reset_signal (async, active-high)
//   arm, abort, shot_count, stop_on_error      host controls
//   exp_state                                  scenario_state from experiment FSM
//   exp_start, exp_reset                       controls to experiment FSM
//   busy, done, aborted                        status
//   shots_done, shots_ok, error_count          per-sequence counters
//   seq_state                                  current state encoding
module experiment_sequencer #(
    parameter int unsigned SHOT_W        = 16,
    parameter int unsigned SHOT_TIMEOUT  = 200_000_000,
    parameter int unsigned GAP_LEN       = 2_000_000,
    parameter int unsigned RESET_LEN     = 4,
    parameter logic [7:0]  EXP_IDLE_CODE = 8'd0,
    parameter logic [7:0]  EXP_DONE_CODE = 8'd10
) (
    input  logic              clock,
    input  logic              reset_signal,
    input  logic              arm,
    input  logic              abort,
    input  logic [SHOT_W-1:0] shot_count,
    input  logic              stop_on_error,
    input  logic [7:0]        exp_state,
    output logic              exp_start,
    output logic              exp_reset,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [SHOT_W-1:0] shots_done,
    output logic [SHOT_W-1:0] shots_ok,
    output logic [SHOT_W-1:0] error_count,
    output logic [2:0]        seq_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam int unsigned WDOG_W = $clog2(SHOT_TIMEOUT + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_LEN + 1);
    localparam int unsigned RST_W  = $clog2(RESET_LEN + 1);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(SHOT_TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_LEN - 1);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);
    localparam logic [SHOT_W-1:0] SHOT_ONE  = SHOT_W'(1);
    localparam logic [SHOT_W-1:0] SHOT_MAX  = '1;

    logic [SHOT_W-1:0] target;
    logic              stop_err;
    logic              abort_pend;
    logic [WDOG_W-1:0] wdog;
    logic [GAP_W-1:0]  gap_cnt;
    logic [RST_W-1:0]  rst_cnt;
    logic [SHOT_W-1:0] shots_done_inc;
    logic              shot_active;

    assign shots_done_inc = shots_done + SHOT_ONE;
    assign shot_active = (seq_state == ST_START) ||
                         (seq_state == ST_RUN) ||
                         (seq_state == ST_RELEASE);

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            seq_state   <= ST_IDLE;
            exp_start   <= 1'b0;
            exp_reset   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            shots_done  <= '0;
            shots_ok    <= '0;
            error_count <= '0;
            target      <= '0;
            stop_err    <= 1'b0;
            abort_pend  <= 1'b0;
            wdog        <= '0;
            gap_cnt     <= '0;
            rst_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (shot_active)
                wdog <= wdog + WDOG_ONE;

            case (seq_state)
                ST_IDLE, ST_DONE: begin
                    // arm beats a simultaneous abort here; abort alone is ignored
                    if (arm) begin
                        target      <= shot_count;
                        stop_err    <= stop_on_error;
                        shots_done  <= '0;
                        shots_ok    <= '0;
                        error_count <= '0;
                        aborted     <= 1'b0;
                        abort_pend  <= 1'b0;
                        if (shot_count == '0) begin
                            seq_state <= ST_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            seq_state <= ST_START;
                            exp_start <= 1'b1;
                            wdog      <= '0;
                            busy      <= 1'b1;
                        end
                    end
                end

                ST_START, ST_RUN, ST_RELEASE: begin
                    // priority: abort, then FSM progress, then watchdog
                    if (abort) begin
                        seq_state  <= ST_RECOVER;
                        abort_pend <= 1'b1;
                        exp_start  <= 1'b0;
                        exp_reset  <= 1'b1;
                        rst_cnt    <= '0;
                    end else if (seq_state == ST_START &&
                                 exp_state != EXP_IDLE_CODE) begin
                        seq_state <= ST_RUN;
                    end else if (seq_state == ST_RUN &&
                                 exp_state == EXP_DONE_CODE) begin
                        seq_state <= ST_RELEASE;
                        exp_start <= 1'b0;
                    end else if (seq_state == ST_RELEASE &&
                                 exp_state == EXP_IDLE_CODE) begin
                        shots_done <= shots_done_inc;
                        shots_ok   <= shots_ok + SHOT_ONE;
                        if (shots_done_inc == target) begin
                            seq_state <= ST_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            seq_state <= ST_GAP;
                            gap_cnt   <= '0;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        seq_state  <= ST_RECOVER;
                        exp_start  <= 1'b0;
                        exp_reset  <= 1'b1;
                        rst_cnt    <= '0;
                        shots_done <= shots_done_inc;
                        if (error_count != SHOT_MAX)
                            error_count <= error_count + SHOT_ONE;
                    end
                end

                ST_GAP: begin
                    if (abort) begin
                        seq_state  <= ST_RECOVER;
                        abort_pend <= 1'b1;
                        exp_reset  <= 1'b1;
                        rst_cnt    <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        seq_state <= ST_START;
                        exp_start <= 1'b1;
                        wdog      <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end
                end

                ST_RECOVER: begin
                    if (abort)
                        abort_pend <= 1'b1;
                    rst_cnt <= rst_cnt + RST_ONE;
                    if (rst_cnt == RST_LAST) begin
                        exp_reset <= 1'b0;
                        if (abort_pend || abort || stop_err) begin
                            seq_state <= ST_DONE;
                            aborted   <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else if (shots_done == target) begin
                            seq_state <= ST_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            seq_state <= ST_GAP;
                            gap_cnt   <= '0;
                        end
                    end
                end

                default: begin
                    seq_state <= ST_IDLE;
                    exp_start <= 1'b0;
                    exp_reset <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
